// File: rtl/blink_speed_ctrl_pkg.sv
// Shared blink-rate definitions for the blink speed controller and the debouncer-side top.
package blink_speed_ctrl_pkg;

  localparam int unsigned BLINK_LVL_W   = 2;
  localparam int unsigned BLINK_LVL_MAX = 3;

  typedef logic [BLINK_LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    PRESS_NONE,
    PRESS_UP,
    PRESS_DN
  } press_e;

  // Each level halves the base half-period once more.
  function automatic int unsigned lvl_shift(input lvl_t lvl);
    return 32'(lvl);
  endfunction

endpackage

// File: rtl/blink_speed_ctrl_prescaler.sv
// Blink prescaler: counts 0..half_m1, strobes tc on the terminal count; clr restarts the count.
module blink_prescaler #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic [CNT_W-1:0] half_m1,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    tc = (cnt == half_m1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/blink_speed_ctrl.sv
// Four-level LED blink-rate controller driven by debounced press pulses.
// Optional speed-down button enabled by defining BLINK_DOWN_EN.
module blink_speed_ctrl
  import blink_speed_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 125_000_000,
  parameter int unsigned BASE_HZ = 1,
  parameter int unsigned CNT_W   = 26
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   BTN_UP,
`ifdef BLINK_DOWN_EN
  input  logic                   BTN_DN,
`endif
  output logic                   LED,
  output logic [BLINK_LVL_W-1:0] SPEED
);

  localparam logic [CNT_W-1:0] HALF0 = CNT_W'(CLK_HZ / (2 * BASE_HZ));

  press_e           press;
  logic             clr;
  logic             tc;
  logic [CNT_W-1:0] half_m1;

  always_comb begin
    press = PRESS_NONE;
`ifdef BLINK_DOWN_EN
    // Simultaneous up and down cancel out and leave the count running.
    case ({BTN_UP, BTN_DN})
      2'b10:   press = PRESS_UP;
      2'b01:   press = PRESS_DN;
      default: press = PRESS_NONE;
    endcase
`else
    if (BTN_UP) press = PRESS_UP;
`endif
    clr = (press != PRESS_NONE);
  end

  always_comb begin
    half_m1 = (HALF0 >> lvl_shift(SPEED)) - CNT_W'(1);
  end

  blink_prescaler #(
    .CNT_W(CNT_W)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (clr),
    .half_m1(half_m1),
    .tc     (tc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      LED   <= 1'b0;
      SPEED <= '0;
    end else begin
      if (tc) LED <= ~LED;
      case (press)
        PRESS_UP: SPEED <= (SPEED == lvl_t'(BLINK_LVL_MAX)) ? '0 : SPEED + lvl_t'(1);
        PRESS_DN: SPEED <= (SPEED == '0) ? lvl_t'(BLINK_LVL_MAX) : SPEED - lvl_t'(1);
        default:  SPEED <= SPEED;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// Self-checking bench for blink_speed_ctrl at CLK_HZ=16, BASE_HZ=1 (half-periods 8/4/2/1).
// Down-button scenarios are built only when BLINK_DOWN_EN is defined.
module tb_blink_speed_ctrl;

  logic       CLK;
  logic       RST;
  logic       BTN_UP;
`ifdef BLINK_DOWN_EN
  logic       BTN_DN;
`endif
  logic       LED;
  logic [1:0] SPEED;

  typedef struct {
    logic       led;
    logic [1:0] spd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  blink_speed_ctrl #(
    .CLK_HZ (16),
    .BASE_HZ(1),
    .CNT_W  (4)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .BTN_UP(BTN_UP),
`ifdef BLINK_DOWN_EN
    .BTN_DN(BTN_DN),
`endif
    .LED   (LED),
    .SPEED (SPEED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_dn(input logic v);
`ifdef BLINK_DOWN_EN
    BTN_DN = v;
`endif
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    BTN_UP = 1'b0;
    set_dn(1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    RST    = 1'b1;
    BTN_UP = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      sb.push_back('{led: 1'b0, spd: 2'd0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL reset k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    RST    = 1'b0;
    BTN_UP = 1'b0;
  endtask

  task automatic test_free_run();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      BTN_UP = 1'b0;
      sb.push_back('{led: 1'((k / 8) % 2), spd: 2'd0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL free_run k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
  endtask

  task automatic test_single_up();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      BTN_UP = (k == 1);
      sb.push_back('{led: 1'(((k - 1) / 4) % 2), spd: 2'd1});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL single_up k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    BTN_UP = 1'b0;
  endtask

  task automatic test_four_ups();
    exp_t        e;
    logic [0:17] tl = 18'b000001101000000001;
    int          ts[18] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      BTN_UP = (k == 1) || (k == 4) || (k == 7) || (k == 10);
      sb.push_back('{led: tl[k-1], spd: 2'(ts[k-1])});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL four_ups k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    BTN_UP = 1'b0;
  endtask

  task automatic test_press_on_tc();
    exp_t e;
    logic l;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      BTN_UP = (k == 8);
      l = (k >= 8) && (k < 12);
      sb.push_back('{led: l, spd: (k >= 8) ? 2'd1 : 2'd0});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL press_on_tc k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    BTN_UP = 1'b0;
  endtask

  task automatic test_mid_reset();
    exp_t        e;
    logic [0:12] tl = 13'b0001000000001;
    int          ts[13] = '{1, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      RST    = (k == 5);
      BTN_UP = (k == 1) || (k == 2) || (k == 5);
      sb.push_back('{led: tl[k-1], spd: 2'(ts[k-1])});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL mid_reset k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    RST    = 1'b0;
    BTN_UP = 1'b0;
  endtask

`ifdef BLINK_DOWN_EN
  task automatic test_down();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_dn(k == 1);
      sb.push_back('{led: (k == 2), spd: 2'd3});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL down_wrap k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    set_dn(1'b0);
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      BTN_UP = (k == 1) || (k == 3);
      set_dn(k == 3);
      sb.push_back('{led: 1'(((k - 1) / 4) % 2), spd: 2'd1});
      @(posedge CLK); #1;
      e = sb.pop_front();
      checks++;
      if ({LED, SPEED} !== {e.led, e.spd}) begin
        errors++;
        $display("FAIL up_dn_cancel k=%0d: got LED=%b SPEED=%0d, want LED=%b SPEED=%0d", k, LED, SPEED, e.led, e.spd);
      end
    end
    BTN_UP = 1'b0;
    set_dn(1'b0);
  endtask
`endif

  initial begin
    RST    = 1'b1;
    BTN_UP = 1'b0;
    set_dn(1'b0);
    @(negedge CLK);
    test_reset();
    test_free_run();
    test_single_up();
    test_four_ups();
    test_press_on_tc();
    test_mid_reset();
`ifdef BLINK_DOWN_EN
    test_down();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
